boss_anim_seq: RTL and testbench
================================

Name: boss_anim_seq

Overview:
- Upstream of the colour mapper: a per-frame sequencer for the boss sprite.
- Owns boss health and the special-attack (electrified platform) cycle.
- Produces the walk-frame index, walking flag, facing direction, special-attack flag and electricity frame that select boss and brick sprite ROMs during pixel drawing.
- All timing advances on the once-per-frame tick; the only asynchronous path is reset.

Parameters:
- WALK_DIV, 8: frame ticks per walk-animation step.
- ATTACK_PERIOD, 600: frame ticks spent in WALK/IDLE before a charge begins.
- CHARGE_FRAMES, 60: frame ticks in CHARGE.
- ATTACK_FRAMES, 120: frame ticks in ATTACK.
- ELEC_DIV, 4: frame ticks per elec_frame toggle.
- MAX_HEALTH, 320: reset/restart health (health bar pixel width).
- HIT_DAMAGE, 8: health removed per hit.

Ports:
- Clk  in  1  system clock
- Reset_n  in  1  asynchronous active-low reset
- frame_tick  in  1  one-Clk pulse per video frame
- restart  in  1  one-Clk pulse, return to game start
- boss_moving  in  1  boss motion block reports nonzero X velocity
- boss_vel_right  in  1  1 = moving right
- hit  in  1  one-Clk pulse, player bullet struck boss
- walk_frame_boss  out  2  walk sprite index 0..2
- is_walking_boss  out  1  walking sprite select
- boss_direction  out  1  1 = facing right
- boss_special_attack  out  1  attack active (electrified bricks, recoloured boss)
- elec_frame  out  1  electricity sprite select
- boss_health  out  10  remaining health
- boss_dead  out  1  health exhausted

Behaviour:
- Reset (Reset_n low, async): state IDLE, health MAX_HEALTH, all counters 0.
  - Outputs at reset: walk_frame_boss 0, is_walking_boss 0, boss_direction 0, boss_special_attack 0, elec_frame 0, boss_dead 0.
- All outputs are registered. State and counters change only on cycles with frame_tick=1, except the hit, restart and death paths.
- States: IDLE, WALK, CHARGE, ATTACK, DEAD.
- IDLE/WALK:
  - IDLE→WALK when boss_moving=1 on a tick; WALK→IDLE when boss_moving=0 on a tick.
  - The period counter counts ticks across both states.
  - At count ATTACK_PERIOD-1: go to CHARGE and clear the counter.
- WALK:
  - is_walking_boss=1.
  - Divider counts 0..WALK_DIV-1; on wrap, walk_frame_boss advances 0→1→2→0. Value 3 is never produced.
  - Leaving WALK: walk_frame_boss=0 and the divider is cleared.
- Direction:
  - boss_direction loads boss_vel_right on ticks where boss_moving=1, in IDLE/WALK only.
  - Held through CHARGE/ATTACK/DEAD.
- CHARGE:
  - is_walking_boss=0, boss_special_attack=0.
  - After CHARGE_FRAMES ticks → ATTACK.
- ATTACK:
  - boss_special_attack=1.
  - elec_frame toggles every ELEC_DIV ticks, starting at 0 on entry.
  - After ATTACK_FRAMES ticks → IDLE; elec_frame forced 0, period counter 0.
- Hits:
  - hit on any Clk cycle in IDLE/WALK/CHARGE/ATTACK: health ← health−HIT_DAMAGE, saturating at 0, visible the next cycle.
  - hit in DEAD is ignored.
- Death:
  - When updated health = 0: next cycle state DEAD, regardless of frame_tick.
  - In DEAD: boss_dead=1; is_walking_boss, boss_special_attack and elec_frame are all 0; walk_frame_boss=0.
- Restart:
  - restart in any state: same values as reset, synchronously, next cycle.
- Simultaneous events:
  - restart has priority over hit and frame_tick.
  - hit and frame_tick in the same cycle are both applied.
  - A killing hit on the ATTACK→IDLE tick goes to DEAD.
- Widths: health arithmetic is 10-bit unsigned with a compare-before-subtract saturation. Counters are sized to the largest parameter.

Optional Feature:
- Macro: BOSS_RAGE_EN.
- Defined: while boss_health < MAX_HEALTH/2, the effective ATTACK_PERIOD and WALK_DIV are halved (integer shift) at the next counter comparison. Counters are not reset on rage entry; if a counter already exceeds the new limit, it triggers at the next tick.
- Undefined: the periods are fixed, and no rage comparator is synthesised.

Test Plan:
- Reset_n low mid-ATTACK → all outputs 0 asynchronously, boss_health=320 once released.
- boss_moving=1, boss_vel_right=1, ticks every 10 Clk → walk_frame_boss sequence 0,1,2,0 changing every 8 ticks; boss_direction=1.
- 600 ticks in WALK → CHARGE (special=0) for 60 ticks, then special=1 for 120 ticks with elec_frame toggling every 4 ticks, then IDLE with special=0.
- 40 hit pulses → health 320→0 in steps of 8; boss_dead=1 the cycle after the 40th hit; a further hit leaves health at 0.
- hit and restart in the same cycle with health 16 → health 320, state IDLE.
- With BOSS_RAGE_EN, health 152 → CHARGE after 300 ticks and walk step every 4 ticks. Without the macro → still 600 ticks and 8.

Source files
------------

// File: rtl/boss_anim_seq_if.sv
// Boss animation sequencer bus.
// Groups the per-frame event inputs and the sprite-select / health outputs.
// master: the game-side block that raises events and consumes sprite selects.
// slave:  the sequencer itself.
interface boss_anim_seq_if;
    // Event strobes are single-cycle pulses: frame_tick once per video frame,
    // restart and hit once per occurrence. There is no back-pressure; a pulse
    // is consumed on the cycle it is high. boss_moving/boss_vel_right are levels.
    logic       frame_tick;
    logic       restart;
    logic       boss_moving;
    logic       boss_vel_right;
    logic       hit;

    logic [1:0] walk_frame_boss;
    logic       is_walking_boss;
    logic       boss_direction;
    logic       boss_special_attack;
    logic       elec_frame;
    logic [9:0] boss_health;
    logic       boss_dead;

    modport master (
        output frame_tick, restart, boss_moving, boss_vel_right, hit,
        input  walk_frame_boss, is_walking_boss, boss_direction,
               boss_special_attack, elec_frame, boss_health, boss_dead
    );

    modport slave (
        input  frame_tick, restart, boss_moving, boss_vel_right, hit,
        output walk_frame_boss, is_walking_boss, boss_direction,
               boss_special_attack, elec_frame, boss_health, boss_dead
    );
endinterface

// File: rtl/boss_anim_seq.sv
// Boss animation sequencer: per-frame state machine for the boss sprite.
// Owns boss health, the walk animation and the charge/attack (electrified
// platform) cycle. Everything advances on frame_tick except hits, restart and
// the death transition, which act on any clock cycle.
// Optional build macro BOSS_RAGE_EN: while health is below half of MAX_HEALTH
// the attack period and walk divider are halved.
module boss_anim_seq #(
    parameter int WALK_DIV      = 8,
    parameter int ATTACK_PERIOD = 600,
    parameter int CHARGE_FRAMES = 60,
    parameter int ATTACK_FRAMES = 120,
    parameter int ELEC_DIV      = 4,
    parameter int MAX_HEALTH    = 320,
    parameter int HIT_DAMAGE    = 8
) (
    input  logic            Clk,
    input  logic            Reset_n,
    boss_anim_seq_if.slave  bus,
    output logic [2:0]      dbg_state
);

    // One counter width covers every count range in the block.
    localparam int M1      = (ATTACK_PERIOD > CHARGE_FRAMES) ? ATTACK_PERIOD : CHARGE_FRAMES;
    localparam int M2      = (ATTACK_FRAMES > WALK_DIV) ? ATTACK_FRAMES : WALK_DIV;
    localparam int M3      = (M1 > M2) ? M1 : M2;
    localparam int CNT_MAX = (M3 > ELEC_DIV) ? M3 : ELEC_DIV;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] PERIOD_LIM = CNT_W'(ATTACK_PERIOD - 1);
    localparam logic [CNT_W-1:0] WALK_LIM   = CNT_W'(WALK_DIV - 1);
    localparam logic [CNT_W-1:0] CHARGE_LIM = CNT_W'(CHARGE_FRAMES - 1);
    localparam logic [CNT_W-1:0] ATTACK_LIM = CNT_W'(ATTACK_FRAMES - 1);
    localparam logic [CNT_W-1:0] ELEC_LIM   = CNT_W'(ELEC_DIV - 1);
    localparam logic [9:0]       HEALTH_RST = 10'(MAX_HEALTH);
    localparam logic [9:0]       DAMAGE     = 10'(HIT_DAMAGE);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WALK   = 3'd1,
        ST_CHARGE = 3'd2,
        ST_ATTACK = 3'd3,
        ST_DEAD   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] period_q, period_d;     // ticks spent roaming (IDLE+WALK)
    logic [CNT_W-1:0] walk_div_q, walk_div_d; // ticks since last walk step
    logic [CNT_W-1:0] phase_q, phase_d;       // ticks spent in CHARGE or ATTACK
    logic [CNT_W-1:0] elec_div_q, elec_div_d; // ticks since last elec toggle
    logic [1:0]       walk_frame_q, walk_frame_d;
    logic             dir_q, dir_d;
    logic             elec_q, elec_d;
    logic [9:0]       health_q, health_d;
    logic             walking_q, walking_d;
    logic             special_q, special_d;
    logic             dead_q, dead_d;

    logic [CNT_W-1:0] period_lim;
    logic [CNT_W-1:0] walk_lim;
    logic [9:0]       health_hit;
    logic             hit_apply;

`ifdef BOSS_RAGE_EN
    localparam logic [CNT_W-1:0] PERIOD_LIM_RAGE = CNT_W'((ATTACK_PERIOD >> 1) - 1);
    localparam logic [CNT_W-1:0] WALK_LIM_RAGE   = CNT_W'((WALK_DIV >> 1) - 1);
    logic rage;

    // Rage halves the roaming period and walk step while health is low.
    always_comb begin
        rage       = (health_q < (HEALTH_RST >> 1));
        period_lim = rage ? PERIOD_LIM_RAGE : PERIOD_LIM;
        walk_lim   = rage ? WALK_LIM_RAGE   : WALK_LIM;
    end
`else
    // Fixed limits when rage is not built.
    always_comb begin
        period_lim = PERIOD_LIM;
        walk_lim   = WALK_LIM;
    end
`endif

    // Saturating damage: compare before subtracting so health never wraps.
    always_comb begin
        hit_apply  = bus.hit && (state_q != ST_DEAD);
        health_hit = (health_q >= DAMAGE) ? (health_q - DAMAGE) : 10'd0;
    end

    // Next-state and next-output logic. Limits compare with >= so a counter
    // already past a freshly shortened limit fires on the next tick.
    always_comb begin
        state_d      = state_q;
        period_d     = period_q;
        walk_div_d   = walk_div_q;
        phase_d      = phase_q;
        elec_div_d   = elec_div_q;
        walk_frame_d = walk_frame_q;
        dir_d        = dir_q;
        elec_d       = elec_q;
        health_d     = health_q;

        unique case (state_q)
            ST_IDLE, ST_WALK: begin
                if (bus.frame_tick) begin
                    if (bus.boss_moving) begin
                        dir_d = bus.boss_vel_right;
                    end
                    if (period_q >= period_lim) begin
                        state_d      = ST_CHARGE;
                        period_d     = '0;
                        phase_d      = '0;
                        walk_div_d   = '0;
                        walk_frame_d = 2'd0;
                    end else begin
                        period_d = period_q + 1'b1;
                        if (state_q == ST_WALK) begin
                            if (!bus.boss_moving) begin
                                state_d      = ST_IDLE;
                                walk_div_d   = '0;
                                walk_frame_d = 2'd0;
                            end else if (walk_div_q >= walk_lim) begin
                                walk_div_d   = '0;
                                walk_frame_d = (walk_frame_q == 2'd2) ? 2'd0 : walk_frame_q + 2'd1;
                            end else begin
                                walk_div_d = walk_div_q + 1'b1;
                            end
                        end else if (bus.boss_moving) begin
                            state_d = ST_WALK;
                        end
                    end
                end
            end
            ST_CHARGE: begin
                if (bus.frame_tick) begin
                    if (phase_q >= CHARGE_LIM) begin
                        state_d    = ST_ATTACK;
                        phase_d    = '0;
                        elec_div_d = '0;
                        elec_d     = 1'b0;
                    end else begin
                        phase_d = phase_q + 1'b1;
                    end
                end
            end
            ST_ATTACK: begin
                if (bus.frame_tick) begin
                    if (phase_q >= ATTACK_LIM) begin
                        state_d    = ST_IDLE;
                        phase_d    = '0;
                        elec_div_d = '0;
                        elec_d     = 1'b0;
                        period_d   = '0;
                    end else begin
                        phase_d = phase_q + 1'b1;
                        if (elec_div_q >= ELEC_LIM) begin
                            elec_div_d = '0;
                            elec_d     = ~elec_q;
                        end else begin
                            elec_div_d = elec_div_q + 1'b1;
                        end
                    end
                end
            end
            default: begin
                // DEAD holds until restart or reset.
            end
        endcase

        // Hits land on any cycle; a killing hit overrides any tick transition.
        if (hit_apply) begin
            health_d = health_hit;
            if (health_hit == 10'd0) begin
                state_d      = ST_DEAD;
                period_d     = '0;
                walk_div_d   = '0;
                phase_d      = '0;
                elec_div_d   = '0;
                walk_frame_d = 2'd0;
                elec_d       = 1'b0;
            end
        end

        // Restart wins over everything and mirrors the reset values.
        if (bus.restart) begin
            state_d      = ST_IDLE;
            period_d     = '0;
            walk_div_d   = '0;
            phase_d      = '0;
            elec_div_d   = '0;
            walk_frame_d = 2'd0;
            dir_d        = 1'b0;
            elec_d       = 1'b0;
            health_d     = HEALTH_RST;
        end

        walking_d = (state_d == ST_WALK);
        special_d = (state_d == ST_ATTACK);
        dead_d    = (state_d == ST_DEAD);
    end

    // State, counters and registered outputs.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= ST_IDLE;
            period_q     <= '0;
            walk_div_q   <= '0;
            phase_q      <= '0;
            elec_div_q   <= '0;
            walk_frame_q <= 2'd0;
            dir_q        <= 1'b0;
            elec_q       <= 1'b0;
            health_q     <= HEALTH_RST;
            walking_q    <= 1'b0;
            special_q    <= 1'b0;
            dead_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            period_q     <= period_d;
            walk_div_q   <= walk_div_d;
            phase_q      <= phase_d;
            elec_div_q   <= elec_div_d;
            walk_frame_q <= walk_frame_d;
            dir_q        <= dir_d;
            elec_q       <= elec_d;
            health_q     <= health_d;
            walking_q    <= walking_d;
            special_q    <= special_d;
            dead_q       <= dead_d;
        end
    end

    assign bus.walk_frame_boss     = walk_frame_q;
    assign bus.is_walking_boss     = walking_q;
    assign bus.boss_direction      = dir_q;
    assign bus.boss_special_attack = special_q;
    assign bus.elec_frame          = elec_q;
    assign bus.boss_health         = health_q;
    assign bus.boss_dead           = dead_q;
    assign dbg_state               = state_q;

endmodule

// File: tb/tb_boss_anim_seq.sv
// Testbench for boss_anim_seq: random and directed event streams checked
// against a phase/tick-count model of the boss behaviour.
module tb_boss_anim_seq;

    localparam int WALK_DIV      = 8;
    localparam int ATTACK_PERIOD = 600;
    localparam int CHARGE_FRAMES = 60;
    localparam int ATTACK_FRAMES = 120;
    localparam int ELEC_DIV      = 4;
    localparam int MAX_HEALTH    = 320;
    localparam int HIT_DAMAGE    = 8;
    localparam int BOUND         = 3000;

    localparam int P_ROAM   = 0;
    localparam int P_CHARGE = 1;
    localparam int P_ATTACK = 2;
    localparam int P_DEAD   = 3;

    // ---------------- clock / reset ----------------
    logic       Clk     = 1'b0;
    logic       Reset_n = 1'b0;
    logic [2:0] dbg_state;

    always #5 Clk = ~Clk;

    boss_anim_seq_if bus ();

    boss_anim_seq dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard ----------------
    logic [16:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    // ---------------- reference model ----------------
    int m_phase, m_walking, m_per, m_wd, m_frame, m_dir, m_ct, m_at, m_elec, m_health;
    bit cur_moving = 1'b0;
    bit cur_right  = 1'b0;

    task automatic model_reset();
        m_phase = P_ROAM; m_walking = 0; m_per = 0; m_wd = 0; m_frame = 0;
        m_dir = 0; m_ct = 0; m_at = 0; m_elec = 0; m_health = MAX_HEALTH;
    endtask

    function automatic logic [16:0] model_out();
        logic [16:0] v;
        v = {2'(m_frame), 1'(m_phase == P_ROAM && m_walking == 1), 1'(m_dir),
             1'(m_phase == P_ATTACK), 1'(m_elec), 10'(m_health), 1'(m_phase == P_DEAD)};
        return v;
    endfunction

    task automatic model_cycle(input bit tick, input bit hit, input bit rst,
                               input bit moving, input bit right);
        int  eff_per;
        int  eff_div;
        bit  killed;
        if (rst) begin
            model_reset();
            return;
        end
        eff_per = ATTACK_PERIOD;
        eff_div = WALK_DIV;
`ifdef BOSS_RAGE_EN
        if (m_health < MAX_HEALTH / 2) begin
            eff_per = ATTACK_PERIOD / 2;
            eff_div = WALK_DIV / 2;
        end
`endif
        killed = 1'b0;
        if (hit && m_phase != P_DEAD) begin
            m_health = (m_health >= HIT_DAMAGE) ? m_health - HIT_DAMAGE : 0;
            killed   = (m_health == 0);
        end
        if (tick) begin
            case (m_phase)
                P_ROAM: begin
                    if (moving) m_dir = right;
                    if (m_per + 1 >= eff_per) begin
                        m_phase = P_CHARGE; m_per = 0; m_walking = 0;
                        m_wd = 0; m_frame = 0; m_ct = 0;
                    end else begin
                        m_per++;
                        if (m_walking == 1) begin
                            if (!moving) begin
                                m_walking = 0; m_frame = 0; m_wd = 0;
                            end else if (m_wd + 1 >= eff_div) begin
                                m_wd = 0; m_frame = (m_frame + 1) % 3;
                            end else begin
                                m_wd++;
                            end
                        end else if (moving) begin
                            m_walking = 1;
                        end
                    end
                end
                P_CHARGE: begin
                    m_ct++;
                    if (m_ct == CHARGE_FRAMES) begin
                        m_phase = P_ATTACK; m_at = 0; m_elec = 0;
                    end
                end
                P_ATTACK: begin
                    m_at++;
                    if (m_at == ATTACK_FRAMES) begin
                        m_phase = P_ROAM; m_walking = 0; m_at = 0; m_elec = 0; m_per = 0;
                    end else begin
                        m_elec = (m_at / ELEC_DIV) % 2;
                    end
                end
                default: ;
            endcase
        end
        if (killed) begin
            m_phase = P_DEAD; m_walking = 0; m_frame = 0; m_elec = 0;
            m_per = 0; m_wd = 0; m_ct = 0; m_at = 0;
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive(input bit tick, input bit hit, input bit rst);
        bus.frame_tick     = tick;
        bus.hit            = hit;
        bus.restart        = rst;
        bus.boss_moving    = cur_moving;
        bus.boss_vel_right = cur_right;
        @(posedge Clk);
        #1;
        model_cycle(tick, hit, rst, cur_moving, cur_right);
        exp_q.push_back(model_out());
        @(negedge Clk);
        bus.frame_tick = 1'b0;
        bus.hit        = 1'b0;
        bus.restart    = 1'b0;
    endtask

    task automatic tick_n(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            for (int j = 1; j < gap; j++) drive(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic hits(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b1, 1'b0);
    endtask

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Tick until boss_special_attack equals want; n returns the tick count.
    task automatic ticks_until_special(input bit want, output int n);
        n = 0;
        while (bus.boss_special_attack !== want && n < BOUND) begin
            drive(1'b1, 1'b0, 1'b0);
            n++;
        end
        if (n >= BOUND) check("special_timeout", n, -1);
    endtask

    // ---------------- monitor ----------------
    always @(negedge Clk) begin
        logic [16:0] exp_v;
        logic [16:0] got_v;
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            got_v = {bus.walk_frame_boss, bus.is_walking_boss, bus.boss_direction,
                     bus.boss_special_attack, bus.elec_frame, bus.boss_health, bus.boss_dead};
            n_checks++;
            if (got_v !== exp_v) begin
                n_errors++;
                $display("FAIL outputs t=%0t got frame=%0d walk=%0b dir=%0b spc=%0b elec=%0b hp=%0d dead=%0b expected frame=%0d walk=%0b dir=%0b spc=%0b elec=%0b hp=%0d dead=%0b",
                         $time, got_v[16:15], got_v[14], got_v[13], got_v[12], got_v[11], got_v[10:1], got_v[0],
                         exp_v[16:15], exp_v[14], exp_v[13], exp_v[12], exp_v[11], exp_v[10:1], exp_v[0]);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int total;
        int exp_per;
        int exp_div;

        bus.frame_tick = 0; bus.hit = 0; bus.restart = 0;
        bus.boss_moving = 0; bus.boss_vel_right = 0;
        model_reset();
        repeat (2) @(negedge Clk);
        check("rst_health", bus.boss_health, MAX_HEALTH);
        check("rst_outs", {bus.walk_frame_boss, bus.is_walking_boss, bus.boss_direction,
                           bus.boss_special_attack, bus.elec_frame, bus.boss_dead}, 0);
        Reset_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0);

        // Walk animation with slow ticks, then the full charge/attack cycle.
        cur_moving = 1; cur_right = 1;
        tick_n(30, 10);
        check("dir_right", bus.boss_direction, 1);
        ticks_until_special(1'b1, n);
        check("ticks_to_attack", n + 30, ATTACK_PERIOD + CHARGE_FRAMES);
        ticks_until_special(1'b0, n);
        check("attack_len", n, ATTACK_FRAMES);

        // Asynchronous reset in the middle of an attack.
        ticks_until_special(1'b1, n);
        tick_n(5, 1);
        check("elec_mid_attack", bus.elec_frame, 1);
        #2 Reset_n = 1'b0;
        #1;
        check("async_rst_outs", {bus.walk_frame_boss, bus.is_walking_boss, bus.boss_direction,
                                 bus.boss_special_attack, bus.elec_frame, bus.boss_dead}, 0);
        check("async_rst_health", bus.boss_health, MAX_HEALTH);
        model_reset();
        cur_moving = 0; cur_right = 0;
        @(negedge Clk);
        Reset_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0);

        // 40 hits drain health; a further hit is ignored.
        for (int i = 0; i < 40; i++) drive(1'($urandom_range(0, 1)), 1'b1, 1'b0);
        check("dead_after_40", bus.boss_dead, 1);
        check("health_zero", bus.boss_health, 0);
        drive(1'b1, 1'b1, 1'b0);
        check("health_stays_zero", bus.boss_health, 0);

        // Restart beats a simultaneous hit and tick.
        drive(1'b0, 1'b0, 1'b1);
        hits(38);
        check("health_16", bus.boss_health, 16);
        cur_moving = 1;
        drive(1'b1, 1'b1, 1'b1);
        check("restart_hit_health", bus.boss_health, MAX_HEALTH);
        check("restart_hit_idle", bus.is_walking_boss, 0);
        check("restart_hit_alive", bus.boss_dead, 0);

        // Low-health timing (halved only when rage is built).
        cur_moving = 0;
        hits(21);
        check("health_152", bus.boss_health, 152);
`ifdef BOSS_RAGE_EN
        exp_per = ATTACK_PERIOD / 2;
        exp_div = WALK_DIV / 2;
`else
        exp_per = ATTACK_PERIOD;
        exp_div = WALK_DIV;
`endif
        cur_moving = 1; cur_right = 0;
        drive(1'b1, 1'b0, 1'b0);
        total = 1;
        n = 0;
        while (bus.walk_frame_boss !== 2'd1 && n < BOUND) begin
            drive(1'b1, 1'b0, 1'b0);
            n++;
        end
        check("low_hp_walk_step", n, exp_div);
        total += n;
        n = 0;
        while (bus.is_walking_boss === 1'b1 && n < BOUND) begin
            drive(1'b1, 1'b0, 1'b0);
            n++;
        end
        check("low_hp_period", total + n, exp_per);

        // Killing hit on the final attack tick goes to DEAD.
        drive(1'b0, 1'b0, 1'b1);
        cur_moving = 0;
        hits(39);
        ticks_until_special(1'b1, n);
        tick_n(ATTACK_FRAMES - 1, 1);
        check("attack_last_tick", bus.boss_special_attack, 1);
        drive(1'b1, 1'b1, 1'b0);
        check("kill_on_exit_dead", bus.boss_dead, 1);
        check("kill_on_exit_spc", bus.boss_special_attack, 0);

        // Random event stream.
        drive(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 49) == 0) cur_moving = ~cur_moving;
            if ($urandom_range(0, 29) == 0) cur_right = ~cur_right;
            drive(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 59) == 0),
                  1'($urandom_range(0, 999) == 0));
        end

        repeat (2) @(negedge Clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
